// File: rtl/apb_arb_pkg.sv
// Shared types for the two-requester APB4 master: FSM states,
// slave address windows and the address decoder.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    localparam logic [31:0] S0_BASE = 32'h0000_1000;
    localparam logic [31:0] S0_END  = 32'h0000_1FFF;
    localparam logic [31:0] S1_BASE = 32'h0000_2000;
    localparam logic [31:0] S1_END  = 32'h0000_2FFF;

    typedef logic slv_idx_t;

    typedef struct packed {
        logic     hit;
        slv_idx_t idx;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] addr);
        dec_t d;
        d.hit = 1'b0;
        d.idx = 1'b0;
        if (addr >= S0_BASE && addr <= S0_END) begin
            d.hit = 1'b1;
        end else if (addr >= S1_BASE && addr <= S1_END) begin
            d.hit = 1'b1;
            d.idx = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer names the favoured requester
// and moves past the winner only when a grant is taken.
module apb_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_q;

    always_comb begin
        gnt = 2'b00;
        if (ptr_q) begin
            gnt = req[1] ? 2'b10 : {1'b0, req[0]};
        end else begin
            gnt = req[0] ? 2'b01 : {req[1], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (advance && (|gnt)) begin
            ptr_q <= gnt[0];
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB4 master shared by two requesters with SETUP/ACCESS sequencing.
// Optional ACCESS timeout: define APB_ARB_TIMEOUT_EN.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                PCLK,
    input  logic                                PRESET,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ-1:0][3:0]             req_strb,
    input  logic [NUM_REQ-1:0][2:0]             req_prot,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic                                rsp_err,
    output logic [1:0]                          PSEL,
    output logic                                PENABLE,
    output logic                                PWRITE,
    output logic [2:0]                          PPROT,
    output logic [ADDR_WIDTH-1:0]               PADDR,
    output logic [DATA_WIDTH-1:0]               PWDATA,
    output logic [3:0]                          PSTRB,
    input  logic [DATA_WIDTH-1:0]               PRDATA_S0,
    input  logic [DATA_WIDTH-1:0]               PRDATA_S1,
    input  logic                                PREADY_S0,
    input  logic                                PREADY_S1,
    input  logic                                PSLVERR_S0,
    input  logic                                PSLVERR_S1
);

    state_t state_q, state_d;

    logic [1:0]            gnt;
    logic                  gidx;
    dec_t                  dec;
    logic                  accept, sample, tout, timeout_hit;
    logic                  pready, pslverr;
    logic [DATA_WIDTH-1:0] prdata;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [3:0]            strb_q;
    logic [2:0]            prot_q;
    logic                  write_q, owner_q, err_q;
    slv_idx_t              idx_q;

    apb_rr_arbiter u_rr (
        .clk     (PCLK),
        .rst     (PRESET),
        .req     (req_valid),
        .advance (accept),
        .gnt     (gnt)
    );

    assign gidx = gnt[1];
    assign dec  = decode(32'(req_addr[gidx]));

    // Only the selected slave's response lines are looked at
    assign pready  = idx_q ? PREADY_S1  : PREADY_S0;
    assign pslverr = idx_q ? PSLVERR_S1 : PSLVERR_S0;
    assign prdata  = idx_q ? PRDATA_S1  : PRDATA_S0;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tcnt_q <= '0;
        end else if (state_q == SETUP) begin
            tcnt_q <= '0;
        end else if (state_q == ACCESS) begin
            tcnt_q <= tcnt_q + 1'b1;
        end
    end

    assign timeout_hit = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        sample  = 1'b0;
        tout    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    accept  = 1'b1;
                    state_d = dec.hit ? SETUP : RESP;
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (pready) begin
                    sample  = 1'b1;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    tout    = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            write_q <= 1'b0;
            owner_q <= 1'b0;
            idx_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr[gidx];
                wdata_q <= req_wdata[gidx];
                strb_q  <= req_write[gidx] ? req_strb[gidx] : 4'b0000;
                prot_q  <= req_prot[gidx];
                write_q <= req_write[gidx];
                owner_q <= gidx;
                idx_q   <= dec.idx;
                rdata_q <= '0;
                err_q   <= ~dec.hit;
            end
            if (sample) begin
                err_q   <= pslverr;
                rdata_q <= (write_q || pslverr) ? '0 : prdata;
            end
            if (tout) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

    logic bus_on, in_resp;
    assign bus_on  = (state_q == SETUP) || (state_q == ACCESS);
    assign in_resp = (state_q == RESP);

    assign req_ready = accept ? gnt : 2'b00;
    assign rsp_valid = in_resp ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata = in_resp ? rdata_q : '0;
    assign rsp_err   = in_resp & err_q;

    assign PSEL    = bus_on ? (idx_q ? 2'b10 : 2'b01) : 2'b00;
    assign PENABLE = (state_q == ACCESS);
    assign PWRITE  = write_q;
    assign PPROT   = prot_q;
    assign PADDR   = addr_q;
    assign PWDATA  = wdata_q;
    assign PSTRB   = strb_q;

endmodule
